// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction loader: FSM state encoding and stream/word widths.
package loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DAT_LO = 3'd3,
        DAT_HI = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } loader_state_t;

endpackage

// File: rtl/instr_loader.sv
// Byte-stream program loader: parses LEN/DATA/CSUM from the host and writes 9-bit words into
// instruction memory, holding the CPU in reset while a load is in progress.
module instr_loader
    import loader_pkg::*;
#(
    parameter int D = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [D-1:0]      wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [D:0]        words_loaded,
    output loader_state_t     state
);

    localparam logic [16:0] CAPACITY = 17'(1) << D;

    loader_state_t     state_q, state_d;
    logic [BYTE_W-1:0] len_lo_q;
    logic [15:0]       len_q;
    logic [BYTE_W-1:0] lo_q;
    logic [BYTE_W-1:0] csum_q;
    logic [D:0]        cnt_q;
    logic              wr_en_q;
    logic [D-1:0]      wr_addr_q;
    logic [WORD_W-1:0] wr_data_q;

    logic        xfer;
    logic        start_ok;
    logic [16:0] len_full;
    logic        len_ok;
    logic        last_word;

    // Handshake: a byte moves on any cycle with in_valid & in_ready; in_ready depends only on state.
    assign in_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DAT_LO) ||
                       (state_q == DAT_HI) || (state_q == CSUM);
    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign len_full  = {1'b0, in_data, len_lo_q};
    assign len_ok    = (len_full != 17'd0) && (len_full <= CAPACITY);
    // The index has not yet advanced for the word being transferred, hence the +1.
    assign last_word = ((17'(cnt_q) + 17'd1) >= {1'b0, len_q});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = LEN_LO;
            LEN_LO:          if (xfer) state_d = LEN_HI;
            LEN_HI:          if (xfer) state_d = len_ok ? DAT_LO : ERR;
            DAT_LO:          if (xfer) state_d = DAT_HI;
            DAT_HI:          if (xfer) state_d = last_word ? CSUM : DAT_LO;
            CSUM:            if (xfer) state_d = (in_data == csum_q) ? DONE : ERR;
            default:         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_lo_q  <= '0;
            len_q     <= '0;
            lo_q      <= '0;
            csum_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_ok) begin
                cnt_q  <= '0;
                csum_q <= '0;
            end
            if (xfer) begin
                case (state_q)
                    LEN_LO: len_lo_q <= in_data;
                    LEN_HI: len_q <= {in_data, len_lo_q};
                    DAT_LO: begin
                        lo_q   <= in_data;
                        csum_q <= csum_q ^ in_data;
                    end
                    DAT_HI: begin
                        csum_q    <= csum_q ^ in_data;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q[D-1:0];
                        wr_data_q <= {in_data[0], lo_q};
                        cnt_q     <= cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign words_loaded = cnt_q;
    assign cpu_hold     = in_ready;
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERR);
    assign state        = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: stimulus pushes expected {addr,data} writes into a queue,
// and a negedge monitor pops and compares every write strobe the loader produces.
module tb_instr_loader;
    import loader_pkg::*;

    localparam int D = 10;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [D-1:0]      wr_addr;
    logic [8:0]        wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [D:0]        words_loaded;
    loader_state_t     state;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [D+8:0] last_wr = '0;
    logic [D+8:0] exp_q[$];
    logic [8:0]   img[0:1023];

    instr_loader #(.D(D)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            wr_count++;
            last_wr = {wr_addr, wr_data};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h:%0h expected=none", wr_addr, wr_data);
            end else begin
                chk("write", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout actual=in_ready_low expected=in_ready_high");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_status(input string tag, input loader_state_t st, input logic d,
                                input logic e, input logic h, input int wl);
        chk({tag, "_state"}, 32'(st == state), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(wl));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic run_load(input int n, input bit bad_csum, input bit gaps, input bit mid_start,
                            input int abort_after, input bit junk);
        logic [7:0]  x;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] nl;
        x  = 8'h00;
        nl = 16'(n);
        pulse_start();
        chk("load_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("load_state_len_lo", 32'(state == LEN_LO), 32'd1);
        send_byte(nl[7:0]);
        send_byte(nl[15:8]);
        for (int i = 0; i < n; i++) begin
            lo = img[i][7:0];
            hi = {(junk ? 7'($urandom_range(0, 127)) : 7'd0), img[i][8]};
            x  = x ^ lo ^ hi;
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(lo);
            if (mid_start && i == 1) pulse_start();
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            exp_q.push_back({D'(i), img[i]});
            send_byte(hi);
            if (i == abort_after) begin
                repeat (2) @(negedge clk);
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
        end
        send_byte(bad_csum ? 8'h00 : x);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset held two cycles: everything idle and zero.
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        check_status("rst", IDLE, 1'b0, 1'b0, 1'b0, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Three-word image: bytes 03 00 A5 01 03 00 00 01 A6.
        img[0] = 9'h1A5;
        img[1] = 9'h003;
        img[2] = 9'h100;
        run_load(3, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        check_status("load3", DONE, 1'b1, 1'b0, 1'b0, 3);
        chk("load3_writes", 32'(wr_count), 32'd3);

        // Same image, checksum byte 0x00: writes stay, load ends in error.
        run_load(3, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        check_status("badcsum", ERR, 1'b0, 1'b1, 1'b0, 3);
        chk("badcsum_writes", 32'(wr_count), 32'd6);

        // Illegal lengths rejected right after LEN_HI.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check_status("len0", ERR, 1'b0, 1'b1, 1'b0, 0);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        repeat (3) @(negedge clk);
        check_status("len401", ERR, 1'b0, 1'b1, 1'b0, 0);
        chk("badlen_writes", 32'(wr_count), 32'd6);

        // Random stalls and a mid-stream start pulse change nothing.
        run_load(3, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        check_status("gaps", DONE, 1'b1, 1'b0, 1'b0, 3);
        chk("gaps_writes", 32'(wr_count), 32'd9);

        // Reset after word 1: back to idle, no further writes.
        run_load(3, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        check_status("abort", IDLE, 1'b0, 1'b0, 1'b0, 0);
        repeat (20) @(negedge clk);
        chk("abort_writes", 32'(wr_count), 32'd11);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_still_idle", 32'(state == IDLE), 32'd1);

        // Full-capacity image with junk in DATA_HI[7:1].
        for (int i = 0; i < 1024; i++) img[i] = 9'((i * 37 + 5) % 512);
        run_load(1024, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        check_status("full", DONE, 1'b1, 1'b0, 1'b0, 1024);
        chk("full_writes", 32'(wr_count), 32'd1035);
        chk("full_last_addr", 32'(last_wr[D+8:9]), 32'h3FF);
        chk("full_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
